median_seq: RTL
===============

// Module: median_seq
// PURPOSE
//  Sequencer for the MED compare-exchange median shift register (W-bit, P taps).
//  Accepts a burst of P pixels from the window source, then drives MED's DSI/BYP
//  through the fixed compare/bypass pass schedule. Flags DSO for one cycle when
//  MED's DO holds the median. Sits between the window generator and the MED instance.
// PARAMETERS
//  P   9   taps of the controlled MED; odd, >= 3
//  CW  16  width of optional result counter (MEDIAN_PERF_EN)
// PORTS
//  CLK      in   1              clock; all logic on posedge
//  nRST     in   1              synchronous reset, active-low
//  DSI      in   1              source pixel strobe; must stay high P consecutive cycles
//  MED_DSI  out  1              to MED.DSI; load DI into R[0]
//  MED_BYP  out  1              to MED.BYP; 1 = shift, 0 = compare-exchange (max kept)
//  DSO      out  1              one-cycle pulse: MED.DO is the median this cycle
//  BUSY     out  1              high from first accepted DSI until DSO cycle inclusive
//  ERR      out  1              sticky protocol error; cleared only by reset
//  RES_CNT  out  CW             completed medians (only with MEDIAN_PERF_EN)
// BEHAVIOUR
//  Reset (nRST=0 at posedge): state IDLE, counters 0, ERR=0, RES_CNT=0.
//   Outputs during/after reset: MED_DSI=0, MED_BYP=1, DSO=0, BUSY=0.
//  Reset mid-operation aborts the sequence; no DSO for the aborted window.
//  MED_DSI = DSI & (state in {IDLE, LOAD, DONE}): combinational, 0 latency to DI.
//  States / transitions (K = (P-1)/2 passes, pass index i = 0..K-1):
//   IDLE : BYP=1. DSI=1 -> LOAD, load count = 1.
//   LOAD : BYP=1, BUSY=1. DSI=1 -> count++; count reaches P -> CMP, i=0.
//          DSI=0 before P loads -> ERR=1, back to IDLE (partial window dropped).
//   CMP  : BYP=0, DSI=0 to MED. Held P-1-i cycles -> ROT.
//   ROT  : BYP=1. Held i+1 cycles; then i++; i==K -> FIN, else -> CMP.
//   FIN  : BYP=0. Held K cycles -> DONE.
//   DONE : DSO=1, BUSY=1, BYP=1, one cycle.
//          DSI=1 -> LOAD, count = 1 (back-to-back window accepted).
//          DSI=0 -> IDLE.
//  Each CMP+ROT pass lasts exactly P cycles.
//  Latency: first DSI at cycle t0 -> DSO at t0 + P + K*P + K.
//   For P=9: t0+49 (load t0..t0+8, passes t0+9..t0+44, FIN t0+45..t0+48).
//  DSI=1 in CMP/ROT/FIN: ignored (MED_DSI stays 0), ERR=1, sequence continues.
//  Counters: $clog2(P+1) bits. No wrap within a window; every count is bounded by P.
//  Throughput: one median per P+K*P+K+1 cycles, or per P+K*P+K cycles when back-to-back.
// CONFIGURATION
//  MEDIAN_PERF_EN defined:
//   - RES_CNT increments on each DSO cycle.
//   - RES_CNT wraps modulo 2^CW; reset to 0.
//  MEDIAN_PERF_EN undefined:
//   - RES_CNT port absent; no counter logic.
//   - All other behaviour identical.
// TESTING (P=9, MED instance + median reference model)
//  1. Reset, then DSI high 9 cycles with DI=5,1,9,3,7,2,8,4,6
//     -> DSO exactly at t0+49, DO=5, BUSY high t0..t0+49, ERR=0.
//  2. Two windows back-to-back (DSI high in DONE cycle), DI=0..8 then 8..0
//     -> two DSO pulses 49 cycles apart, both DO=4.
//  3. DSI drops after 5 loads -> ERR=1, state IDLE, no DSO.
//     Next full window -> correct median, ERR stays 1.
//  4. DSI pulsed mid-CMP -> MED_DSI stays 0, ERR=1, DSO still at t0+49 with correct median.
//  5. nRST=0 at t0+20 for 1 cycle -> MED_DSI=0, MED_BYP=1, BUSY=0, no DSO.
//     Fresh window afterwards -> correct result.
//  6. MEDIAN_PERF_EN, CW=4: run 17 windows -> RES_CNT=1.
//     Build without macro -> compiles with no RES_CNT port.

Source files
------------

// File: rtl/median_seq_if.sv
// Handshake bundle between the window source, the median sequencer and MED.
// The sequencer is the slave; the source/test side is the master.
interface median_seq_if;
  logic DSI;
  logic MED_DSI;
  logic MED_BYP;
  logic DSO;
  logic BUSY;
  logic ERR;

  modport master (
    output DSI,
    input  MED_DSI,
    input  MED_BYP,
    input  DSO,
    input  BUSY,
    input  ERR
  );

  modport slave (
    input  DSI,
    output MED_DSI,
    output MED_BYP,
    output DSO,
    output BUSY,
    output ERR
  );
endinterface

// File: rtl/median_seq.sv
// Sequencer driving a P-tap MED compare-exchange shift register.
// Optional result counter RES_CNT is enabled by defining MEDIAN_PERF_EN.
module median_seq #(
  parameter int P  = 9,
  parameter int CW = 16
) (
  input  logic          CLK,
  input  logic          nRST,
  median_seq_if.slave   bus
`ifdef MEDIAN_PERF_EN
  ,
  output logic [CW-1:0] RES_CNT
`endif
);

  localparam int K  = (P - 1) / 2;
  localparam int NW = $clog2(P + 1);

  localparam logic [NW-1:0] C_ONE  = NW'(1);
  localparam logic [NW-1:0] C_LLD  = NW'(P - 1);
  localparam logic [NW-1:0] C_CMP  = NW'(P - 2);
  localparam logic [NW-1:0] C_LPS  = NW'(K - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CMP,
    S_ROT,
    S_FIN,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_nxt;
  logic [NW-1:0] r_cnt;
  logic [NW-1:0] w_cnt;
  logic [NW-1:0] r_pass;
  logic [NW-1:0] w_pass;
  logic          r_err;
  logic          w_err;
  logic          w_dsi_ok;
  logic          w_cmp;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pass  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt;
      r_pass  <= w_pass;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_nxt  = r_state;
    w_cnt  = r_cnt;
    w_pass = r_pass;
    w_err  = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (bus.DSI) begin
          w_nxt = S_LOAD;
          w_cnt = C_ONE;
        end
      end
      S_LOAD: begin
        if (!bus.DSI) begin
          w_nxt = S_IDLE;
          w_cnt = '0;
          w_err = 1'b1;
        end else if (r_cnt == C_LLD) begin
          w_nxt  = S_CMP;
          w_cnt  = '0;
          w_pass = '0;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_CMP: begin
        if (bus.DSI) w_err = 1'b1;
        // compare phase shrinks by one cycle per pass
        if (r_cnt == C_CMP - r_pass) begin
          w_nxt = S_ROT;
          w_cnt = '0;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_ROT: begin
        if (bus.DSI) w_err = 1'b1;
        if (r_cnt == r_pass) begin
          w_cnt = '0;
          if (r_pass == C_LPS) begin
            w_nxt = S_FIN;
          end else begin
            w_nxt  = S_CMP;
            w_pass = r_pass + C_ONE;
          end
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_FIN: begin
        if (bus.DSI) w_err = 1'b1;
        if (r_cnt == C_LPS) begin
          w_nxt = S_DONE;
          w_cnt = '0;
        end else begin
          w_cnt = r_cnt + C_ONE;
        end
      end
      S_DONE: begin
        if (bus.DSI) begin
          w_nxt = S_LOAD;
          w_cnt = C_ONE;
        end else begin
          w_nxt = S_IDLE;
        end
      end
      default: begin
        w_nxt = S_IDLE;
        w_cnt = '0;
      end
    endcase
  end

  assign w_dsi_ok = (r_state == S_IDLE) ||
                    (r_state == S_LOAD) ||
                    (r_state == S_DONE);
  assign w_cmp    = (r_state == S_CMP) ||
                    (r_state == S_FIN);

  // outputs are forced safe while reset is asserted
  assign bus.MED_DSI = nRST & bus.DSI & w_dsi_ok;
  assign bus.MED_BYP = ~nRST | ~w_cmp;
  assign bus.DSO     = nRST & (r_state == S_DONE);
  assign bus.BUSY    = nRST & ((r_state != S_IDLE) | bus.DSI);
  assign bus.ERR     = r_err;

`ifdef MEDIAN_PERF_EN
  logic [CW-1:0] r_res_cnt;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_res_cnt <= '0;
    end else if (r_state == S_DONE) begin
      r_res_cnt <= r_res_cnt + 1'b1;
    end
  end

  assign RES_CNT = r_res_cnt;
`endif

endmodule
